output_port_controller: RTL and testbench

OUTPUT_PORT_CONTROLLER -- requirements
Module: output_port_controller

---
 rtl/output_port_pkg.sv | 14 +
 rtl/output_port_fifo.sv | 55 +++++
 rtl/output_port_controller.sv | 127 ++++++++++++
 tb/tb_output_port_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/output_port_pkg.sv
// Shared definitions for the output port controller: FSM state encoding
// and default sizing for the FIFO depth and the post-transfer hold gap.
package output_port_pkg;

  localparam int DEPTH_DEFAULT       = 4;
  localparam int HOLD_CYCLES_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } port_state_e;

endpackage

// File: rtl/output_port_fifo.sv
// Word FIFO behind the output port: storage, wrapping pointers and fill
// count. Exposes the head word and the word behind it so the controller
// can present the next entry on the same edge that pops the current one.
module output_port_fifo
  import output_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                head_o,
  output logic [31:0]                head_next_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_inc;
  logic [CW-1:0] count_q;

  // Storage is data only; it needs no reset because count gates its use.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rptr_inc    = rptr_q + 1'b1;
  assign head_o      = mem_q[rptr_q];
  assign head_next_o = mem_q[rptr_inc];
  assign count_o     = count_q;

endmodule

// File: rtl/output_port_controller.sv
// CPU output port: buffers OUT-instruction words in a FIFO and hands them
// to a peripheral with a valid/ready handshake. The CPU is stalled when it
// writes into a full FIFO. Defining OUTPUT_PORT_HOLD_EN inserts an idle gap
// of HOLD_CYCLES cycles (out_valid low) after every transfer.
module output_port_controller
  import output_port_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   out_write,
  input  logic [31:0]            data_out,
  output logic                   cpu_stall,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  port_state_e state_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic        full;
  logic        push;
  logic        pop;
  logic [31:0] head;
  logic [31:0] head_next;

`ifdef OUTPUT_PORT_HOLD_EN
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [TW-1:0] hold_timer_q;
  logic          unused_head_next;
  assign unused_head_next = ^head_next;
`else
  logic unused_hold_cycles;
  assign unused_hold_cycles = (HOLD_CYCLES != 0);
`endif

  // Full comes from the registered count, so a pop on the same edge does
  // not make room for a push.
  assign full      = (count == CW'(DEPTH));
  assign cpu_stall = out_write & full;
  assign push      = out_write & ~full;
  assign pop       = out_valid_q & out_ready;

  output_port_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (data_out),
    .head_o      (head),
    .head_next_o (head_next),
    .count_o     (count)
  );

  // Presentation FSM; out_data/out_valid are registered and always mirror
  // the FIFO head while valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
`ifdef OUTPUT_PORT_HOLD_EN
      hold_timer_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // FIFO is empty here, so the word being pushed becomes the head.
          if (push) begin
            state_q     <= ST_PRESENT;
            out_valid_q <= 1'b1;
            out_data_q  <= data_out;
          end
        end
        ST_PRESENT: begin
          if (pop) begin
`ifdef OUTPUT_PORT_HOLD_EN
            state_q      <= ST_HOLD;
            out_valid_q  <= 1'b0;
            hold_timer_q <= TW'(HOLD_CYCLES - 1);
`else
            if (count > CW'(1)) begin
              out_data_q <= head_next;
            end else if (push) begin
              out_data_q <= data_out;
            end else begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
`endif
          end
        end
`ifdef OUTPUT_PORT_HOLD_EN
        ST_HOLD: begin
          if (hold_timer_q != '0) begin
            hold_timer_q <= hold_timer_q - 1'b1;
          end else if (count != '0) begin
            state_q     <= ST_PRESENT;
            out_valid_q <= 1'b1;
            out_data_q  <= head;
          end else if (push) begin
            state_q     <= ST_PRESENT;
            out_valid_q <= 1'b1;
            out_data_q  <= data_out;
          end else begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_output_port_controller.sv
// Self-checking bench for output_port_controller: directed scenarios plus
// biased random traffic, all compared against a queue-based reference.
module tb_output_port_controller;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
`ifdef OUTPUT_PORT_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out_write = 1'b0;
  logic [31:0] data_out = '0;
  logic        cpu_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  output_port_controller #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_write (out_write),
    .data_out  (data_out),
    .cpu_stall (cpu_stall),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: words stored, whether a word is on offer, idle gap left.
  logic [31:0] q[$];
  bit          m_valid = 1'b0;
  int          m_gap   = 0;

  bit          last_valid;
  logic [31:0] last_data;
  logic [31:0] delivered[$];
  bit          seen5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance the model at posedge.
  task automatic cycle(input bit wr, input logic [31:0] d, input bit rdy);
    bit do_push, do_pop;
    out_write = wr;
    data_out  = d;
    out_ready = rdy;
    @(negedge clock);
    check("count", count, q.size());
    check("valid", out_valid, m_valid);
    check("stall", cpu_stall, (wr && q.size() == DEPTH));
    if (m_valid) check("data", out_data, q[0]);
    last_valid = out_valid;
    last_data  = out_data;
    if (out_valid && rdy) delivered.push_back(out_data);
    if (out_valid && out_data == 32'd5) seen5 = 1'b1;
    @(posedge clock);
    do_pop  = m_valid && rdy;
    do_push = wr && (q.size() < DEPTH);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(d);
    if (HOLD_EN && do_pop) m_gap = HOLD;
    else if (m_gap > 0) m_gap--;
    m_valid = (m_gap == 0) && (q.size() > 0);
    #1;
  endtask

  // Asynchronous reset raised mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    reset     = 1'b1;
    out_write = 1'b1;
    out_ready = 1'b0;
    data_out  = '0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_stall", cpu_stall, 1'b0);
    out_write = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_gap   = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lows, xfers;
    int wr_pct[4]  = '{70, 30, 95, 50};
    int rdy_pct[4] = '{30, 70, 15, 60};

    @(posedge clock);
    #1;
    do_reset();

    // Single word with the peripheral ready: one-cycle latency, then empty.
    cycle(1'b1, 32'h2A, 1'b1);
    check("r030_cnt1", count, 3'd1);
    cycle(1'b0, 32'h0, 1'b1);
    check("r030_valid", last_valid, 1'b1);
    check("r030_data", last_data, 32'h2A);
    check("r030_cnt0", count, 3'd0);

    // Five writes into a four-deep FIFO with the peripheral stalled.
    do_reset();
    seen5 = 1'b0;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
    check("r031_cnt4", count, 3'd4);
    out_write = 1'b1;
    #1;
    check("r031_stall", cpu_stall, 1'b1);
    cycle(1'b1, 32'd5, 1'b0);
    check("r031_still4", count, 3'd4);

    // Stay full for ten cycles, then drain: 1..4 in order, 5 never shown.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      check("r032_hold", last_data, 32'd1);
    end
    delivered.delete();
    for (int i = 0; i < 60 && delivered.size() < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    check("r032_n", delivered.size(), 4);
    for (int i = 0; i < delivered.size() && i < 4; i++)
      check("r032_order", delivered[i], 32'(i + 1));
    for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1);
    check("r031_never5", seen5, 1'b0);
    check("r032_empty", count, 3'd0);

    // Simultaneous push and pop at count=2.
    do_reset();
    cycle(1'b1, 32'h11, 1'b0);
    cycle(1'b1, 32'h22, 1'b0);
    check("r033_cnt2", count, 3'd2);
    cycle(1'b1, 32'h77, 1'b1);
    check("r033_same", count, 3'd2);
    delivered.delete();
    for (int i = 0; i < 60 && delivered.size() < 2; i++) cycle(1'b0, 32'h0, 1'b1);
    check("r033_n", delivered.size(), 2);
    if (delivered.size() == 2) begin
      check("r033_mid", delivered[0], 32'h22);
      check("r033_last", delivered[1], 32'h77);
    end

    // Gap between two queued transfers: HOLD cycles with the hold feature, none without.
    do_reset();
    cycle(1'b1, 32'hA1, 1'b0);
    cycle(1'b1, 32'hA2, 1'b0);
    lows  = 0;
    xfers = 0;
    for (int i = 0; i < 40 && xfers < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (last_valid) xfers++;
      else if (xfers == 1) lows++;
    end
    check("r034_xfers", xfers, 2);
    check("r034_gap", lows, HOLD_EN ? HOLD : 0);

    // Reset with three words queued; push accepted on the first edge after.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
    check("r035_cnt3", count, 3'd3);
    do_reset();
    cycle(1'b1, 32'hBEEF, 1'b0);
    check("r024_push", count, 3'd1);

    // Biased random traffic with occasional mid-operation resets.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 119) == 0) do_reset();
        cycle($urandom_range(0, 99) < wr_pct[p], $urandom, $urandom_range(0, 99) < rdy_pct[p]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
